// File: rtl/ex_hazard_ctrl_if.sv
// Execute-stage hazard controller bundle: ID-stage operand info in, EX selects and IF/ID control out.
// Latency: none, plain signal bundle.
// Backpressure: stall_o/flush_o are the only flow-control signals; there is no ready path back into EX.
interface ex_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid_i;
   logic [REG_ADDR_W-1:0] id_rs1_i;
   logic [REG_ADDR_W-1:0] id_rs2_i;
   logic                  id_use_rs1_i;
   logic                  id_use_rs2_i;
   logic [REG_ADDR_W-1:0] id_rd_i;
   logic                  id_we_i;
   logic                  id_is_load_i;
   logic [2:0]            id_branch_sel_i;
   logic                  ex_isValid_i;
   logic [1:0]            A_sel;
   logic [1:0]            B_sel;
   logic [2:0]            Branch_sel;
   logic                  ex_valid_o;
   logic                  stall_o;
   logic                  flush_o;
   logic [CNT_W-1:0]      mispredict_cnt_o;
   logic [CNT_W-1:0]      stall_cnt_o;

   // Pipeline side: presents the ID instruction and EX's prediction result.
   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_we_i, id_is_load_i, id_branch_sel_i, ex_isValid_i,
      input  A_sel, B_sel, Branch_sel, ex_valid_o, stall_o, flush_o,
             mispredict_cnt_o, stall_cnt_o
   );

   // Hazard controller side.
   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
             id_rd_i, id_we_i, id_is_load_i, id_branch_sel_i, ex_isValid_i,
      output A_sel, B_sel, Branch_sel, ex_valid_o, stall_o, flush_o,
             mispredict_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use stall, mispredict flush, perf counters.
// Latency: selects/ex_valid registered (1 cycle ID->EX); stall_o/flush_o combinational same cycle.
// Backpressure: load-use holds IF/ID for one cycle; a mispredict squashes IF/ID and costs two EX bubbles.
module ex_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
)(
   input  logic            clk,
   input  logic            reset,
   ex_hazard_ctrl_if.slave hz_if
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // Operand mux encodings shared with the EX datapath.
   localparam logic [1:0]            SEL_RF  = 2'b00;
   localparam logic [1:0]            SEL_MEM = 2'b01;
   localparam logic [1:0]            SEL_WB  = 2'b10;
   localparam logic [REG_ADDR_W-1:0] REG_X0  = '0;
   localparam logic [CNT_W-1:0]      CNT_MAX = '1;
   localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_state_nxt;

   // EX tracking entry. Its occupant moves to MEM on the next edge, hence "Data_MEM" forwarding.
   logic                  r_ex_vld;
   logic                  r_ex_we;
   logic                  r_ex_ld;
   logic [REG_ADDR_W-1:0] r_ex_rd;

   // MEM tracking entry. Its occupant moves to WB on the next edge, hence "Data_WB" forwarding.
   // Only EX needs the load flag, and the WB occupant has already reached the register file by the
   // time a following instruction reads operands, so nothing beyond MEM is needed for selection.
   logic                  r_mem_vld;
   logic                  r_mem_we;
   logic [REG_ADDR_W-1:0] r_mem_rd;

   logic [1:0]            r_a_sel;
   logic [1:0]            r_b_sel;
   logic [2:0]            r_br_sel;
   logic [CNT_W-1:0]      r_mispredict_cnt;
   logic [CNT_W-1:0]      r_stall_cnt;

   logic                  w_ex_hit_a;
   logic                  w_ex_hit_b;
   logic                  w_mem_hit_a;
   logic                  w_mem_hit_b;
   logic                  w_load_use;
   logic                  w_mispredict;
   logic                  w_issue;
   logic                  w_stall;
   logic                  w_flush;
   logic [1:0]            w_a_sel;
   logic [1:0]            w_b_sel;

   // A used, non-x0 source matches a valid writing producer.
   assign w_ex_hit_a  = hz_if.id_use_rs1_i && (hz_if.id_rs1_i != REG_X0) &&
                        r_ex_vld && r_ex_we && (r_ex_rd == hz_if.id_rs1_i);
   assign w_ex_hit_b  = hz_if.id_use_rs2_i && (hz_if.id_rs2_i != REG_X0) &&
                        r_ex_vld && r_ex_we && (r_ex_rd == hz_if.id_rs2_i);
   assign w_mem_hit_a = hz_if.id_use_rs1_i && (hz_if.id_rs1_i != REG_X0) &&
                        r_mem_vld && r_mem_we && (r_mem_rd == hz_if.id_rs1_i);
   assign w_mem_hit_b = hz_if.id_use_rs2_i && (hz_if.id_rs2_i != REG_X0) &&
                        r_mem_vld && r_mem_we && (r_mem_rd == hz_if.id_rs2_i);

   // The nearer producer (currently in EX) holds the newest value, so it wins.
   assign w_a_sel = w_ex_hit_a ? SEL_MEM : (w_mem_hit_a ? SEL_WB : SEL_RF);
   assign w_b_sel = w_ex_hit_b ? SEL_MEM : (w_mem_hit_b ? SEL_WB : SEL_RF);

   // Load in EX feeding the ID instruction; only acted on in RUN (LU_STALL never re-detects).
   assign w_load_use   = hz_if.id_valid_i && r_ex_ld && (w_ex_hit_a || w_ex_hit_b);
   // EX's prediction flag is meaningless for a bubble.
   assign w_mispredict = r_ex_vld && !hz_if.ex_isValid_i;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= RUN;
      else       r_state <= w_state_nxt;
   end

   // Next state plus stall/flush/issue decisions; mispredict beats load-use beats issue, all gated by reset.
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_flush     = 1'b0;
      w_issue     = 1'b0;
      if (!reset) begin
         if (w_mispredict) begin
            w_flush     = 1'b1;
            w_state_nxt = FLUSH;
         end else begin
            case (r_state)
               RUN: begin
                  if (w_load_use) begin
                     w_stall     = 1'b1;
                     w_state_nxt = LU_STALL;
                  end else begin
                     w_issue     = hz_if.id_valid_i;
                     w_state_nxt = RUN;
                  end
               end
               LU_STALL: begin
                  // The load has moved to MEM, so the held instruction now forwards from WB path.
                  w_issue     = hz_if.id_valid_i;
                  w_state_nxt = RUN;
               end
               FLUSH: begin
                  // ID holds a wrong-path instruction; drop it.
                  w_state_nxt = RUN;
               end
               default: w_state_nxt = RUN;
            endcase
         end
      end
   end

   // EX/MEM tracking and registered EX controls: issue from ID or insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_vld  <= 1'b0;
         r_ex_we   <= 1'b0;
         r_ex_ld   <= 1'b0;
         r_ex_rd   <= REG_X0;
         r_mem_vld <= 1'b0;
         r_mem_we  <= 1'b0;
         r_mem_rd  <= REG_X0;
         r_a_sel   <= SEL_RF;
         r_b_sel   <= SEL_RF;
         r_br_sel  <= 3'b000;
      end else begin
         r_mem_vld <= r_ex_vld;
         r_mem_we  <= r_ex_we;
         r_mem_rd  <= r_ex_rd;
         if (w_issue) begin
            r_ex_vld <= 1'b1;
            r_ex_we  <= hz_if.id_we_i;
            r_ex_ld  <= hz_if.id_is_load_i;
            r_ex_rd  <= hz_if.id_rd_i;
            r_a_sel  <= w_a_sel;
            r_b_sel  <= w_b_sel;
            r_br_sel <= hz_if.id_branch_sel_i;
         end else begin
            r_ex_vld <= 1'b0;
            r_ex_we  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= REG_X0;
            r_a_sel  <= SEL_RF;
            r_b_sel  <= SEL_RF;
            r_br_sel <= 3'b000;
         end
      end
   end

   // Saturating event counters for mispredict flushes and load-use stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mispredict_cnt <= '0;
         r_stall_cnt      <= '0;
      end else begin
         if (w_flush && (r_mispredict_cnt != CNT_MAX))
            r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
         if (w_stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   assign hz_if.A_sel            = r_a_sel;
   assign hz_if.B_sel            = r_b_sel;
   assign hz_if.Branch_sel       = r_br_sel;
   assign hz_if.ex_valid_o       = r_ex_vld;
   assign hz_if.stall_o          = w_stall;
   assign hz_if.flush_o          = w_flush;
   assign hz_if.mispredict_cnt_o = r_mispredict_cnt;
   assign hz_if.stall_cnt_o      = r_stall_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: table of per-cycle ID/EX inputs with expected outputs, plus reset corner cases.
// Latency: registered expectations queued at drive time and popped one cycle later.
// Backpressure: stall/flush checked combinationally in the driving cycle.
module tb_ex_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] id_rd;
   logic       id_we;
   logic       id_ld;
   logic [2:0] id_br;
   logic       ex_isv;

   always #5 clk = ~clk;

   ex_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();
   ex_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  hz2 ();

   assign hz.id_valid_i       = id_valid;
   assign hz.id_rs1_i         = id_rs1;
   assign hz.id_rs2_i         = id_rs2;
   assign hz.id_use_rs1_i     = id_use_rs1;
   assign hz.id_use_rs2_i     = id_use_rs2;
   assign hz.id_rd_i          = id_rd;
   assign hz.id_we_i          = id_we;
   assign hz.id_is_load_i     = id_ld;
   assign hz.id_branch_sel_i  = id_br;
   assign hz.ex_isValid_i     = ex_isv;
   assign hz2.id_valid_i      = id_valid;
   assign hz2.id_rs1_i        = id_rs1;
   assign hz2.id_rs2_i        = id_rs2;
   assign hz2.id_use_rs1_i    = id_use_rs1;
   assign hz2.id_use_rs2_i    = id_use_rs2;
   assign hz2.id_rd_i         = id_rd;
   assign hz2.id_we_i         = id_we;
   assign hz2.id_is_load_i    = id_ld;
   assign hz2.id_branch_sel_i = id_br;
   assign hz2.ex_isValid_i    = ex_isv;

   ex_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
      .clk   (clk),
      .reset (reset),
      .hz_if (hz)
   );

   // Narrow-counter copy sharing the same stimulus, for saturation.
   ex_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) u_dut_sat (
      .clk   (clk),
      .reset (reset),
      .hz_if (hz2)
   );

   typedef struct {
      int vld, rs1, rs2, u1, u2, rd, we, ld, br, isv;
      int stall, flush;
      int a, b, ebr, exv, scnt, mcnt;
   } vec_t;

   typedef struct {
      int a, b, ebr, exv, scnt, mcnt;
   } exp_t;

   vec_t tbl [29];
   exp_t sb_q [$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic vec_t mk(input int vld, rs1, rs2, u1, u2, rd, we, ld, br, isv,
                               input int st, fl, a, b, ebr, exv, sc, mc);
      vec_t v;
      v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.rd = rd; v.we = we; v.ld = ld; v.br = br; v.isv = isv;
      v.stall = st; v.flush = fl;
      v.a = a; v.b = b; v.ebr = ebr; v.exv = exv; v.scnt = sc; v.mcnt = mc;
      return v;
   endfunction

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic drive(input vec_t v);
      id_valid   = 1'(v.vld);
      id_rs1     = 5'(v.rs1);
      id_rs2     = 5'(v.rs2);
      id_use_rs1 = 1'(v.u1);
      id_use_rs2 = 1'(v.u2);
      id_rd      = 5'(v.rd);
      id_we      = 1'(v.we);
      id_ld      = 1'(v.ld);
      id_br      = 3'(v.br);
      ex_isv     = 1'(v.isv);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_reg(input string tag, input exp_t e);
      chk({tag, "_A_sel"},      int'(hz.A_sel),             e.a);
      chk({tag, "_B_sel"},      int'(hz.B_sel),             e.b);
      chk({tag, "_Branch_sel"}, int'(hz.Branch_sel),        e.ebr);
      chk({tag, "_ex_valid"},   int'(hz.ex_valid_o),        e.exv);
      chk({tag, "_stall_cnt"},  int'(hz.stall_cnt_o),       e.scnt);
      chk({tag, "_misp_cnt"},   int'(hz.mispredict_cnt_o),  e.mcnt);
      chk({tag, "_sat_stall"},  int'(hz2.stall_cnt_o),      sat3(e.scnt));
      chk({tag, "_sat_misp"},   int'(hz2.mispredict_cnt_o), sat3(e.mcnt));
   endtask

   // Step one cycle: drive at posedge+1, sample at the following negedge.
   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
   endtask

   initial begin
      vec_t idle;
      vec_t ld7;
      vec_t dep7;
      exp_t e;
      idle = mk(0,0,0,0,0,0,0,0,0,1, 0,0, 0,0,0,0, 0,0);
      ld7  = mk(1,0,0,0,0,7,1,1,0,1, 0,0, 0,0,0,0, 0,0);
      dep7 = mk(1,7,0,1,0,8,1,0,0,1, 0,0, 0,0,0,0, 0,0);

      //            vld rs1 rs2 u1 u2 rd we ld br isv  st fl  a b ebr exv  sc mc
      tbl[0]  = mk(1, 0, 0, 0,0, 5,1,0,0,1,  0,0,  0,0,0,1,  0,0); // I1 x5<-
      tbl[1]  = mk(1, 5, 0, 1,0, 6,1,0,0,1,  0,0,  1,0,0,1,  0,0); // rs1=5, x5 in EX
      tbl[2]  = mk(1, 0, 5, 0,1, 5,1,0,0,1,  0,0,  0,2,0,1,  0,0); // rs2=5, x5 in MEM
      tbl[3]  = mk(1, 5, 0, 1,0, 5,1,0,0,1,  0,0,  1,0,0,1,  0,0); // x5 again in EX
      tbl[4]  = mk(1, 5, 5, 1,1, 0,0,0,2,1,  0,0,  1,1,2,1,  0,0); // x5 in EX and MEM -> 01
      tbl[5]  = mk(1, 0, 5, 0,1, 0,0,0,0,1,  0,0,  0,2,0,1,  0,0); // EX no write, MEM x5
      tbl[6]  = mk(1, 0, 0, 0,0, 0,1,0,0,1,  0,0,  0,0,0,1,  0,0); // write to x0
      tbl[7]  = mk(1, 0, 0, 1,1, 9,1,0,0,1,  0,0,  0,0,0,1,  0,0); // read x0: no forward
      tbl[8]  = mk(1, 0, 0, 0,0, 7,1,1,0,1,  0,0,  0,0,0,1,  0,0); // load x7
      tbl[9]  = mk(1, 0, 7, 0,1, 8,1,0,0,1,  1,0,  0,0,0,0,  1,0); // load-use stall
      tbl[10] = mk(1, 0, 7, 0,1, 8,1,0,0,0,  0,0,  0,2,0,1,  1,0); // LU_STALL issue, isv ignored
      tbl[11] = mk(0, 0, 0, 0,0, 0,0,0,0,1,  0,0,  0,0,0,0,  1,0);
      tbl[12] = mk(1, 0, 0, 0,0, 0,0,0,1,1,  0,0,  0,0,1,1,  1,0); // branch
      tbl[13] = mk(1, 0, 0, 0,0, 9,1,0,0,0,  0,1,  0,0,0,0,  1,1); // mispredict
      tbl[14] = mk(1, 0, 0, 0,0,10,1,0,0,0,  0,0,  0,0,0,0,  1,1); // FLUSH drops ID
      tbl[15] = mk(1, 9,10, 1,1, 0,0,0,0,1,  0,0,  0,0,0,1,  1,1); // squashed x9/x10 not forwarded
      tbl[16] = mk(1, 0, 0, 0,0,11,1,1,0,1,  0,0,  0,0,0,1,  1,1); // load x11
      tbl[17] = mk(1,11, 0, 1,0,12,1,0,0,0,  0,1,  0,0,0,0,  1,2); // load-use + mispredict
      tbl[18] = mk(1,11, 0, 1,0,12,1,0,0,1,  0,0,  0,0,0,0,  1,2);
      tbl[19] = mk(0, 0, 0, 0,0, 0,0,0,0,1,  0,0,  0,0,0,0,  1,2);
      for (int k = 0; k < 3; k++) begin
         tbl[20+3*k] = mk(1,0,0,0,0,0,0,0,3,1, 0,0, 0,0,3,1, 1,2+k);
         tbl[21+3*k] = mk(0,0,0,0,0,0,0,0,0,0, 0,1, 0,0,0,0, 1,3+k);
         tbl[22+3*k] = mk(0,0,0,0,0,0,0,0,0,1, 0,0, 0,0,0,0, 1,3+k);
      end

      // Reset
      reset = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      e.a = 0; e.b = 0; e.ebr = 0; e.exv = 0; e.scnt = 0; e.mcnt = 0;
      cmp_reg("reset", e);
      chk("reset_stall", int'(hz.stall_o), 0);
      chk("reset_flush", int'(hz.flush_o), 0);

      // Table
      for (int i = 0; i < 29; i++) begin
         step(tbl[i]);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp_reg($sformatf("row%0d", i - 1), e);
         end
         chk($sformatf("row%0d_stall", i), int'(hz.stall_o), tbl[i].stall);
         chk($sformatf("row%0d_flush", i), int'(hz.flush_o), tbl[i].flush);
         e.a = tbl[i].a; e.b = tbl[i].b; e.ebr = tbl[i].ebr;
         e.exv = tbl[i].exv; e.scnt = tbl[i].scnt; e.mcnt = tbl[i].mcnt;
         sb_q.push_back(e);
      end
      step(idle);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         cmp_reg("row28", e);
      end

      // Reset gates stall_o while a load-use hazard is present.
      step(ld7);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(dep7);
      @(negedge clk);
      chk("rst_gate_stall", int'(hz.stall_o), 0);
      chk("rst_gate_flush", int'(hz.flush_o), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(idle);
      @(negedge clk);
      chk("rst1_ex_valid",  int'(hz.ex_valid_o),        0);
      chk("rst1_stall_cnt", int'(hz.stall_cnt_o),       0);
      chk("rst1_misp_cnt",  int'(hz.mispredict_cnt_o),  0);
      chk("rst1_sat_misp",  int'(hz2.mispredict_cnt_o), 0);

      // Reset asserted during LU_STALL.
      step(ld7);
      step(dep7);
      chk("lu2_stall", int'(hz.stall_o), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("lu2_rst_stall", int'(hz.stall_o), 0);
      chk("lu2_rst_flush", int'(hz.flush_o), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(idle);
      @(negedge clk);
      e.a = 0; e.b = 0; e.ebr = 0; e.exv = 0; e.scnt = 0; e.mcnt = 0;
      cmp_reg("lu2_after_rst", e);
      step(mk(1,7,0,1,0,3,1,0,0,1, 0,0, 0,0,0,0, 0,0));
      chk("lu2_run_stall", int'(hz.stall_o), 0);
      step(idle);
      chk("lu2_run_ex_valid", int'(hz.ex_valid_o), 1);
      chk("lu2_run_A_sel",    int'(hz.A_sel),      0);

      // Reset gates flush_o while EX holds a mispredicted branch.
      step(mk(1,0,0,0,0,0,0,0,1,1, 0,0, 0,0,0,0, 0,0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 0,0));
      @(negedge clk);
      chk("rst3_ex_valid", int'(hz.ex_valid_o), 1);
      chk("rst3_flush",    int'(hz.flush_o),    0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(idle);
      @(negedge clk);
      chk("rst3_misp_cnt", int'(hz.mispredict_cnt_o), 0);
      chk("rst3_ex_valid_after", int'(hz.ex_valid_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the execute stage. Tracks destination registers of instructions in EX, MEM and WB. Generates registered forwarding selects (`A_sel`, `B_sel`) and the branch selector for the EX datapath, detects load-use hazards and mispredictions, and issues stall/flush to IF/ID. Sits between the ID/EX pipeline register and EX, and consumes EX's `isValid` result.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid_i` in 1: ID holds a real instruction.
- `id_rs1_i` in REG_ADDR_W: ID source register A.
- `id_rs2_i` in REG_ADDR_W: ID source register B.
- `id_use_rs1_i` in 1: ID instruction reads rs1.
- `id_use_rs2_i` in 1: ID instruction reads rs2.
- `id_rd_i` in REG_ADDR_W: ID destination register.
- `id_we_i` in 1: ID instruction writes rd.
- `id_is_load_i` in 1: ID instruction is a load.
- `id_branch_sel_i` in 3: ID branch type; 000 means not a branch/jump.
- `ex_isValid_i` in 1: EX prediction-correct flag (1 = correct).
- `A_sel` out 2: EX operand A mux select.
- `B_sel` out 2: EX operand B mux select.
- `Branch_sel` out 3: EX branch controller select.
- `ex_valid_o` out 1: EX holds a real instruction.
- `stall_o` out 1: hold PC and IF/ID register this cycle (combinational).
- `flush_o` out 1: squash IF/ID and redirect PC to EX `Correct_PC` this cycle (combinational).
- `mispredict_cnt_o` out CNT_W: saturating mispredict count.
- `stall_cnt_o` out CNT_W: saturating load-use stall count.

## Operation
- Select encoding, matching EX muxes: 00 register file, 01 Data_MEM, 10 Data_WB; 11 is never driven.
- Internal tracking entries, each {valid, rd, we, load}: EX, MEM, WB. Each cycle MEM←EX and WB←MEM unconditionally.
- EX entry:
  - Loads from ID when state is RUN, no stall, no flush, and `id_valid_i`=1.
  - Otherwise it takes a bubble: valid=0, we=0, `Branch_sel`=000, `A_sel`/`B_sel`=00.
- Forwarding is computed at ID→EX transfer, independently for rs1→`A_sel` and rs2→`B_sel`:
  - 01 if the operand is used, rs≠0, the current EX entry is valid with we=1, and rd==rs.
  - Otherwise 10 if the current MEM entry matches the same way.
  - Otherwise 00.
  - MEM-bound match has priority over WB-bound match.
- Load-use hazard: state RUN, `id_valid_i`=1, EX entry valid & load & we, rd≠0, and rd matches a used rs1/rs2.
- Mispredict: `ex_valid_o`=1 and `ex_isValid_i`=0. `ex_isValid_i` is ignored when `ex_valid_o`=0.
- FSM states: RUN, LU_STALL, FLUSH.
  - RUN → LU_STALL on load-use hazard (without mispredict). `stall_o`=1, bubble into EX, `stall_cnt` +1.
  - LU_STALL → RUN after exactly one cycle. In LU_STALL the ID instruction issues with forwarding from MEM (sel 10 for the load result). No re-detection occurs in LU_STALL.
  - Any state → FLUSH on mispredict. `flush_o`=1, `stall_o` forced 0, bubble into EX, `mispredict_cnt` +1.
  - FLUSH → RUN after one cycle. In FLUSH, `id_valid_i` is ignored (wrong-path slot) and a bubble enters EX. A mispredict cannot occur in FLUSH because EX holds a bubble.
- Priority: mispredict > load-use > normal issue.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- `A_sel`, `B_sel`, `Branch_sel`, `ex_valid_o`, tracking entries, state and counters are registered and update on the rising edge.
- `stall_o` and `flush_o` are combinational from ID inputs, tracking entries, state and `ex_isValid_i` in the same cycle.
- Issue latency ID→EX is 1 cycle. A load-use hazard adds exactly 1 bubble. A mispredict costs 2 bubbles: the flush cycle and the FLUSH cycle.
- Reset (synchronous, wins over everything): state RUN, all entries invalid, `A_sel`=`B_sel`=00, `Branch_sel`=000, `ex_valid_o`=0, counters 0.
  - With reset high, the combinational outputs are gated: `stall_o`=0, `flush_o`=0.
  - Reset asserted mid-stall or mid-flush returns to RUN with empty pipeline on the next edge.

## Test plan
- Back-to-back dependency: I1 `x5←`, then I2 reads rs1=5 on the next cycle → I2 in EX with `A_sel`=01. An I3 reading rs2=5 one cycle later gets `B_sel`=10. Same rd in both EX and MEM → 01 wins.
- Writes to x0: I1 rd=0 we=1, I2 reads rs1=0 → `A_sel`=00, no stall.
- Load-use: load `x7`, next instruction reads rs2=7:
  - `stall_o`=1 for one cycle, then one bubble in EX (`ex_valid_o`=0).
  - The dependent instruction then issues with `B_sel`=10.
  - `stall_cnt_o`=1.
- Mispredict: EX branch with `ex_isValid_i`=0 → `flush_o`=1 that cycle, then EX bubbles for 2 cycles and the ID instruction arriving in the FLUSH cycle is dropped. `mispredict_cnt_o` increments by 1.
  - Simultaneous load-use and mispredict → only `flush_o`, `stall_cnt` unchanged.
- Saturation and reset: with `CNT_W`=2, 5 mispredicts → `mispredict_cnt_o`=3. Assert `reset` during LU_STALL → next cycle all outputs at reset values, state RUN.
